// File: rtl/dsp_mac_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate sequencer.
package dsp_mac_pkg;

  localparam logic [7:0] OPM_MUL = 8'h01;
  localparam logic [7:0] OPM_MAC = 8'h09;

  // Slice registers between A/B input and P: A1/B1, M, P.
  localparam int unsigned DSP_LAT = 3;

  typedef enum logic [1:0] {
    FEED,
    DRAIN,
    HOLD
  } state_t;

endpackage

// File: rtl/dsp_rst_sync.sv
// Reset bridge for the DSP slice: asserts asynchronously with rst_n, releases
// synchronously two clock edges after rst_n rises.
module dsp_rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      rst_out <= 1'b1;
    end else begin
      meta    <= 1'b0;
      rst_out <= meta;
    end
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice in MAC mode: streams LEN (a, b) pairs per frame
// through the slice and returns the accumulated sum on a valid/ready port.
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [47:0] m_p,
  output logic [17:0] dsp_A,
  output logic [17:0] dsp_B,
  output logic [7:0]  dsp_OPMODE,
  output logic        dsp_CEA,
  output logic        dsp_CEOPMODE,
  output logic        dsp_CEM,
  output logic        dsp_CEP,
  output logic        dsp_rst,
  input  logic [47:0] dsp_P
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [DSP_LAT-1:0] vpipe;
  logic [DSP_LAT:0]   lpipe;
  logic               f0;
  logic               acc;
  logic               first;
  logic               last;

  dsp_rst_sync u_rst_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_out (dsp_rst)
  );

  assign acc   = s_valid & s_ready;
  assign first = (count == '0);
  assign last  = (count == LAST_CNT);

  // Each slice stage is clocked only when a real pair occupies it, so bubbles
  // never re-accumulate a stale product.
  assign dsp_CEA      = vpipe[0];
  assign dsp_CEOPMODE = vpipe[1];
  assign dsp_CEM      = vpipe[1];
  assign dsp_CEP      = vpipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe      <= '0;
      lpipe      <= '0;
      f0         <= 1'b0;
      dsp_A      <= '0;
      dsp_B      <= '0;
      dsp_OPMODE <= '0;
    end else begin
      vpipe <= {vpipe[DSP_LAT-2:0], acc};
      lpipe <= {lpipe[DSP_LAT-1:0], acc & last};
      f0    <= acc & first;
      if (acc) begin
        dsp_A <= s_a;
        dsp_B <= s_b;
      end
      // Loaded one cycle ahead so it is stable while CEOPMODE is high.
      if (vpipe[0]) begin
        dsp_OPMODE <= f0 ? OPM_MUL : OPM_MAC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FEED;
      count   <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_p     <= '0;
    end else begin
      case (state)
        FEED: begin
          if (acc && last) begin
            count   <= '0;
            s_ready <= 1'b0;
            state   <= DRAIN;
          end else begin
            if (acc) begin
              count <= count + 1'b1;
            end
            s_ready <= ~dsp_rst;
          end
        end
        DRAIN: begin
          s_ready <= 1'b0;
          // Top tag bit: the final product has been in P for one edge.
          if (lpipe[DSP_LAT]) begin
            m_p     <= dsp_P;
            m_valid <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= ~dsp_rst;
            state   <= FEED;
          end else begin
            s_ready <= 1'b0;
          end
        end
        default: begin
          s_ready <= 1'b0;
          state   <= FEED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench: three sequencers (LEN 8, 4, 1), each driving a behavioural
// DSP48A1 slice model.
module tb_dsp_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic [2:0]  s_valid;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic        m_ready;

  logic        s_ready_w    [3];
  logic        m_valid_w    [3];
  logic [47:0] m_p_w        [3];
  logic [17:0] dsp_a_w      [3];
  logic [17:0] dsp_b_w      [3];
  logic [7:0]  dsp_opm_w    [3];
  logic        dsp_cea_w    [3];
  logic        dsp_ceopm_w  [3];
  logic        dsp_cem_w    [3];
  logic        dsp_cep_w    [3];
  logic        dsp_rst_w    [3];
  logic [47:0] dsp_p_w      [3];

  int          checks;
  int          failures;
  int          cyc;
  int          last_acc;
  int          t_mv;
  logic        acc_now;
  logic [2:0]  hist;
  logic        ce_chk;
  int          pa [8];
  int          pb [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic signed [17:0] a_r;
    logic signed [17:0] b_r;
    logic signed [35:0] m_r;
    logic [7:0]         opm_r;
    logic [47:0]        p_r;

    // Behavioural slice: A1/B1, M, OPMODE and P registers, synchronous reset.
    always @(posedge clk) begin
      if (dsp_rst_w[g]) begin
        a_r   <= '0;
        b_r   <= '0;
        m_r   <= '0;
        opm_r <= '0;
        p_r   <= '0;
      end else begin
        if (dsp_cea_w[g]) begin
          a_r <= dsp_a_w[g];
          b_r <= dsp_b_w[g];
        end
        if (dsp_cem_w[g]) m_r <= a_r * b_r;
        if (dsp_ceopm_w[g]) opm_r <= dsp_opm_w[g];
        if (dsp_cep_w[g]) begin
          p_r <= ((opm_r[3:2] == 2'b10) ? p_r : 48'd0) +
                 ((opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0);
        end
      end
    end
    assign dsp_p_w[g] = p_r;

    dsp_mac_sequencer #(
      .LEN   ((g == 0) ? 8 : ((g == 1) ? 4 : 1)),
      .CNT_W (12)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid[g]),
      .s_ready      (s_ready_w[g]),
      .s_a          (s_a),
      .s_b          (s_b),
      .m_valid      (m_valid_w[g]),
      .m_ready      (m_ready),
      .m_p          (m_p_w[g]),
      .dsp_A        (dsp_a_w[g]),
      .dsp_B        (dsp_b_w[g]),
      .dsp_OPMODE   (dsp_opm_w[g]),
      .dsp_CEA      (dsp_cea_w[g]),
      .dsp_CEOPMODE (dsp_ceopm_w[g]),
      .dsp_CEM      (dsp_cem_w[g]),
      .dsp_CEP      (dsp_cep_w[g]),
      .dsp_rst      (dsp_rst_w[g]),
      .dsp_P        (dsp_p_w[g])
    );
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; hist tracks instance-0 accepts.
  task automatic tick;
    acc_now = s_valid[0] & s_ready_w[0];
    @(posedge clk);
    #1;
    cyc++;
    hist = {hist[1:0], acc_now};
    if (ce_chk) begin
      chk("bubble_cea", dsp_cea_w[0], hist[0]);
      chk("bubble_cem", dsp_cem_w[0], hist[1]);
      chk("bubble_ceopm", dsp_ceopm_w[0], hist[1]);
      chk("bubble_cep", dsp_cep_w[0], hist[2]);
    end
  endtask

  task automatic feed(input int idx, input int n, input bit bubble);
    for (int i = 0; i < n; i++) begin
      int w;
      s_a = pa[i][17:0];
      s_b = pb[i][17:0];
      s_valid[idx] = 1'b1;
      w = 0;
      while (!s_ready_w[idx] && w < 20) begin
        tick;
        w++;
      end
      if (!s_ready_w[idx]) chk("sready_timeout", s_ready_w[idx], 1'b1);
      last_acc = cyc;
      tick;
      s_valid[idx] = 1'b0;
      if (bubble && i < n - 1) tick;
    end
  endtask

  task automatic wait_mv(input int idx, output int at);
    int w;
    w = 0;
    while (!m_valid_w[idx] && w < 30) begin
      tick;
      w++;
    end
    at = cyc;
    chk("mvalid_seen", m_valid_w[idx], 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    hist     = '0;
    ce_chk   = 1'b0;
    rst_n    = 1'b0;
    s_valid  = '0;
    s_a      = '0;
    s_b      = '0;
    m_ready  = 1'b0;

    // Reset values
    @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready_w[0], 1'b0);
    chk("rst_m_valid", m_valid_w[0], 1'b0);
    chk("rst_m_p", m_p_w[0], 48'd0);
    chk("rst_dsp_a", dsp_a_w[0], 18'd0);
    chk("rst_opmode", dsp_opm_w[0], 8'h00);
    chk("rst_ce", {dsp_cea_w[0], dsp_ceopm_w[0], dsp_cem_w[0], dsp_cep_w[0]}, 4'b0000);
    chk("rst_dsp_rst", dsp_rst_w[0], 1'b1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rel_dsp_rst_e1", dsp_rst_w[0], 1'b1);
    tick;
    chk("rel_dsp_rst_e2", dsp_rst_w[0], 1'b0);
    chk("rel_s_ready_e2", s_ready_w[0], 1'b0);
    tick;
    chk("rel_s_ready_e3", s_ready_w[0], 1'b1);

    // LEN=8, (k,k) back-to-back: 1+4+...+64 = 204
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pa[i] = i + 1;
      pb[i] = i + 1;
    end
    feed(0, 8, 1'b0);
    chk("t1_sready_after_last", s_ready_w[0], 1'b0);
    wait_mv(0, t_mv);
    chk("t1_latency", t_mv - last_acc, 5);
    chk("t1_sum", m_p_w[0], 48'd204);
    chk("t1_sready_in_hold", s_ready_w[0], 1'b0);
    tick;
    chk("t1_mvalid_fall", m_valid_w[0], 1'b0);
    chk("t1_sready_back", s_ready_w[0], 1'b1);

    // LEN=4 signed extremes: -131070
    pa[0] = -131072; pb[0] = 131071;
    pa[1] = -1;      pb[1] = -1;
    pa[2] = 0;       pb[2] = 5;
    pa[3] = 131071;  pb[3] = 131071;
    feed(1, 4, 1'b0);
    wait_mv(1, t_mv);
    chk("t2_signed_sum", m_p_w[1], -48'sd131070);
    tick;

    // LEN=8 with bubbles: enables follow accepts, sum unchanged
    for (int i = 0; i < 8; i++) begin
      pa[i] = i + 1;
      pb[i] = i + 1;
    end
    ce_chk = 1'b1;
    feed(0, 8, 1'b1);
    wait_mv(0, t_mv);
    ce_chk = 1'b0;
    chk("t3_bubble_sum", m_p_w[0], 48'd204);
    tick;

    // Stall in HOLD for 10 cycles, then a (3,3) frame: 8*9 = 72
    m_ready = 1'b0;
    feed(0, 8, 1'b0);
    wait_mv(0, t_mv);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("t4_hold_m_p", m_p_w[0], 48'd204);
      chk("t4_hold_m_valid", m_valid_w[0], 1'b1);
      chk("t4_hold_s_ready", s_ready_w[0], 1'b0);
      chk("t4_hold_ce", {dsp_cea_w[0], dsp_ceopm_w[0], dsp_cem_w[0], dsp_cep_w[0]}, 4'b0000);
    end
    m_ready = 1'b1;
    tick;
    chk("t4_release", m_valid_w[0], 1'b0);
    for (int i = 0; i < 8; i++) begin
      pa[i] = 3;
      pb[i] = 3;
    end
    feed(0, 8, 1'b0);
    wait_mv(0, t_mv);
    chk("t4_second_frame", m_p_w[0], 48'd72);
    tick;

    // LEN=1: (-7)*6 with OPMODE 01
    pa[0] = -7;
    pb[0] = 6;
    feed(2, 1, 1'b0);
    tick;
    chk("t5_ceopmode", dsp_ceopm_w[2], 1'b1);
    chk("t5_opmode", dsp_opm_w[2], 8'h01);
    wait_mv(2, t_mv);
    chk("t5_product", m_p_w[2], -48'sd42);
    tick;

    // Reset after 3 accepts, then a fresh (1,1) frame: 8
    for (int i = 0; i < 8; i++) begin
      pa[i] = 1;
      pb[i] = 1;
    end
    feed(0, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_s_ready", s_ready_w[0], 1'b0);
    chk("t6_m_valid", m_valid_w[0], 1'b0);
    chk("t6_m_p", m_p_w[0], 48'd0);
    chk("t6_dsp_a", dsp_a_w[0], 18'd0);
    chk("t6_opmode", dsp_opm_w[0], 8'h00);
    chk("t6_ce", {dsp_cea_w[0], dsp_ceopm_w[0], dsp_cem_w[0], dsp_cep_w[0]}, 4'b0000);
    chk("t6_dsp_rst", dsp_rst_w[0], 1'b1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t6_rel_e1", dsp_rst_w[0], 1'b1);
    tick;
    chk("t6_rel_e2", dsp_rst_w[0], 1'b0);
    feed(0, 8, 1'b0);
    wait_mv(0, t_mv);
    chk("t6_fresh_frame", m_p_w[0], 48'd8);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
